// File: rtl/memwb_arbiter_pkg.sv
// Shared state encoding and Wishbone widths for the NOR-memory port arbiter.
package memwb_arbiter_pkg;

    localparam int unsigned WB_AW = 26;
    localparam int unsigned WB_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/memwb_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, with wrap.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic        found;
    int unsigned idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N) idx = idx - N;
            for (int unsigned j = 0; j < N; j++) begin
                if (!found && (j == idx) && req[j]) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/memwb_arbiter.sv
// Round-robin arbiter sharing the nor_bus memwb slave port between NMASTERS masters.
// Optional watchdog enabled by defining MEMWB_ARB_TIMEOUT_EN.
module memwb_arbiter
    import memwb_arbiter_pkg::*;
#(
    parameter int unsigned NMASTERS       = 2,
    parameter int unsigned AW             = WB_AW,
    parameter int unsigned DW             = WB_DW,
    parameter int unsigned MAX_OUTST      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                   sys_clk_i,
    input  logic                   sys_rst_i,
    input  logic [NMASTERS-1:0]    m_cyc_i,
    input  logic [NMASTERS-1:0]    m_stb_i,
    input  logic [NMASTERS-1:0]    m_we_i,
    input  logic [NMASTERS*AW-1:0] m_adr_i,
    input  logic [NMASTERS*DW-1:0] m_dat_i,
    output logic [NMASTERS-1:0]    m_ack_o,
    output logic [NMASTERS-1:0]    m_err_o,
    output logic [NMASTERS-1:0]    m_stall_o,
    output logic [DW-1:0]          m_dat_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic [AW-1:0]          s_adr_o,
    output logic [DW-1:0]          s_dat_o,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,
    input  logic                   s_stall_i,
    input  logic [DW-1:0]          s_dat_i,
    output logic [NMASTERS-1:0]    grant_o,
    output logic                   timeout_o
);

    localparam int unsigned PW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTST) + 1;

    if (NMASTERS < 2 || NMASTERS > 4) begin : g_bad_nmasters
        $error("NMASTERS must be 2..4");
    end
    if ((MAX_OUTST & (MAX_OUTST - 1)) != 0 || MAX_OUTST == 0) begin : g_bad_outst
        $error("MAX_OUTST must be a power of two");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_e          state, state_nxt;
    logic [NMASTERS-1:0] grant_q, pick;
    logic [PW-1:0]       ptr_q, ptr_adv, g_idx;
    logic [CW-1:0]       cnt_q, cnt_nxt;
    logic                g_cyc, g_stb, g_we;
    logic [AW-1:0]       g_adr;
    logic [DW-1:0]       g_dat;
    logic                full, cnt_nz, inc, dec, timeout_hit;

    rr_arbiter #(.N(NMASTERS), .PW(PW)) u_rr (
        .req (m_cyc_i),
        .ptr (ptr_q),
        .gnt (pick)
    );

    // Signals of the current owner
    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_adr = '0;
        g_dat = '0;
        g_idx = '0;
        for (int unsigned k = 0; k < NMASTERS; k++) begin
            if (grant_q[k]) begin
                g_cyc = m_cyc_i[k];
                g_stb = m_stb_i[k];
                g_we  = m_we_i[k];
                g_adr = m_adr_i[k*AW +: AW];
                g_dat = m_dat_i[k*DW +: DW];
                g_idx = PW'(k);
            end
        end
    end

    assign ptr_adv = (g_idx == PW'(NMASTERS - 1)) ? '0 : g_idx + PW'(1);
    assign full    = (cnt_q == CW'(MAX_OUTST));
    assign cnt_nz  = (cnt_q != '0);
    assign inc     = s_stb_o & ~s_stall_i;
    assign dec     = (s_ack_i | s_err_i) & cnt_nz;

`ifdef MEMWB_ARB_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_q;
    logic          wd_run;

    assign wd_run      = (state != ST_IDLE) && cnt_nz && !(s_ack_i || s_err_i);
    assign timeout_hit = (wd_q == WW'(TIMEOUT_CYCLES));

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i || !wd_run || timeout_hit) wd_q <= '0;
        else                                     wd_q <= wd_q + WW'(1);
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Outstanding-strobe counter; a timeout abandons whatever is still owed
    always_comb begin
        cnt_nxt = cnt_q;
        if (inc && !dec)      cnt_nxt = cnt_q + CW'(1);
        else if (dec && !inc) cnt_nxt = cnt_q - CW'(1);
        if (timeout_hit)      cnt_nxt = '0;
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (|m_cyc_i) state_nxt = ST_BUSY;
            ST_BUSY:  if (!g_cyc) state_nxt = (cnt_nxt == '0) ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: if (cnt_nxt == '0) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (timeout_hit) state_nxt = ST_IDLE;
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_nxt;
            if (state == ST_IDLE && state_nxt == ST_BUSY) begin
                grant_q <= pick;
            end else if (state != ST_IDLE && state_nxt == ST_IDLE) begin
                grant_q <= '0;
                ptr_q   <= ptr_adv;
            end
        end
    end

    // CYC stays up while the slave still owes responses, even if the master let go
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_stall_o = '1;
        case (state)
            ST_BUSY: begin
                s_cyc_o   = g_cyc | cnt_nz;
                s_stb_o   = g_cyc & g_stb & ~full & ~timeout_hit;
                s_we_o    = g_we;
                s_adr_o   = g_adr;
                s_dat_o   = g_dat;
                m_stall_o = ~grant_q;
                if (s_stall_i || full) m_stall_o = '1;
                if (s_ack_i && cnt_nz) m_ack_o = grant_q;
                if ((s_err_i && cnt_nz) || timeout_hit) m_err_o = grant_q;
            end
            ST_DRAIN: s_cyc_o = 1'b1;
            default: ;
        endcase
    end

    assign m_dat_o   = s_dat_i;
    assign grant_o   = grant_q;
    assign timeout_o = timeout_hit;

endmodule

// File: tb/tb_memwb_arbiter.sv
// Directed bench for memwb_arbiter with a cycle-level reference model and a delayed-ACK slave.
module tb_memwb_arbiter;

    localparam int NM   = 2;
    localparam int AW   = 26;
    localparam int DW   = 16;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic [NM-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
    logic [NM*AW-1:0] m_adr = '0;
    logic [NM*DW-1:0] m_dat = '0;
    logic [NM-1:0]    m_ack, m_err, m_stall, grant;
    logic [DW-1:0]    m_rdat, s_wdat;
    logic             s_cyc, s_stb, s_we, tmo;
    logic [AW-1:0]    s_adr;
    logic             s_ack = 1'b0, s_err = 1'b0, s_stall = 1'b0;
    logic [DW-1:0]    s_rdat = '0;

    memwb_arbiter dut (
        .sys_clk_i (clk),     .sys_rst_i (rst),
        .m_cyc_i   (m_cyc),   .m_stb_i   (m_stb),   .m_we_i  (m_we),
        .m_adr_i   (m_adr),   .m_dat_i   (m_dat),
        .m_ack_o   (m_ack),   .m_err_o   (m_err),   .m_stall_o (m_stall),
        .m_dat_o   (m_rdat),
        .s_cyc_o   (s_cyc),   .s_stb_o   (s_stb),   .s_we_o  (s_we),
        .s_adr_o   (s_adr),   .s_dat_o   (s_wdat),
        .s_ack_i   (s_ack),   .s_err_i   (s_err),   .s_stall_i (s_stall),
        .s_dat_i   (s_rdat),
        .grant_o   (grant),   .timeout_o (tmo)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- slave: acks each accepted strobe ack_dly cycles later
    int             cyc_cnt = 0;
    int             ack_dly = 2;
    bit             stall_en = 1'b0;
    int             due_q[$];
    logic [AW-1:0]  adr_q[$];

    always @(negedge clk) begin
        if (s_stb && !s_stall && !rst) begin
            due_q.push_back(cyc_cnt + ack_dly);
            adr_q.push_back(s_adr);
        end
    end

    always @(posedge clk) begin
        bit r;
        r = rst;
        cyc_cnt++;
        #1;
        s_stall = stall_en && (cyc_cnt % 3 == 1);
        if (r) begin
            due_q.delete();
            adr_q.delete();
            s_ack = 1'b0;
        end else if (due_q.size() > 0 && cyc_cnt >= due_q[0]) begin
            s_ack  = 1'b1;
            s_rdat = DW'(adr_q[0]) ^ 16'h5A5A;
            void'(due_q.pop_front());
            void'(adr_q.pop_front());
        end else begin
            s_ack = 1'b0;
        end
    end

    // ---------------- monitors
    int            ack_cnt[NM];
    logic [DW-1:0] rd_q[$];
    logic [NM-1:0] gq[$];
    logic [NM-1:0] last_g = '0;

    always @(negedge clk) begin
        for (int k = 0; k < NM; k++) if (m_ack[k]) ack_cnt[k]++;
        if (m_ack[0]) rd_q.push_back(m_rdat);
        if (grant != '0 && grant != last_g) gq.push_back(grant);
        last_g = grant;
    end

    // ---------------- reference model: owner, drain flag, outstanding count, pointer
    int own = -1, outst = 0, ptr = 0;
    bit drn = 1'b0, model_on = 1'b0;
    int n_own = -1, n_outst = 0, n_ptr = 0;
    bit n_drn = 1'b0;
    logic [NM-1:0] e_grant, e_stall, e_ack, e_err;
    bit e_cyc, e_stb, acc, ackerr;

    always @(negedge clk) begin
        if (model_on) begin
            e_grant = (own >= 0) ? NM'(1 << own) : '0;
            e_cyc = 0; e_stb = 0; acc = 0;
            e_stall = '1; e_ack = '0; e_err = '0;
            ackerr = s_ack || s_err;
            if (own >= 0 && !drn) begin
                e_cyc = m_cyc[own] || (outst > 0);
                e_stb = m_cyc[own] && m_stb[own] && (outst < MAXO);
                e_stall[own] = s_stall || (outst == MAXO);
                if (s_ack && outst > 0) e_ack[own] = 1'b1;
                if (s_err && outst > 0) e_err[own] = 1'b1;
                acc = e_stb && !s_stall;
            end else if (own >= 0) begin
                e_cyc = 1;
            end
            chk("cmp_s_cyc", s_cyc, e_cyc);
            chk("cmp_s_stb", s_stb, e_stb);
            chk("cmp_grant", grant, e_grant);
            chk("cmp_stall", m_stall, e_stall);
            chk("cmp_ack", m_ack, e_ack);
            chk("cmp_err", m_err, e_err);
            chk("cmp_rdata", m_rdat, s_rdat);
`ifndef MEMWB_ARB_TIMEOUT_EN
            chk("cmp_timeout", tmo, 0);
`endif
            if (e_stb) begin
                chk("cmp_s_adr", s_adr, m_adr[own*AW +: AW]);
                chk("cmp_s_we", s_we, m_we[own]);
                chk("cmp_s_dat", s_wdat, m_dat[own*DW +: DW]);
            end
            n_own = own; n_drn = drn; n_outst = outst; n_ptr = ptr;
            if (own < 0) begin
                for (int i = 0; i < NM; i++) begin
                    int j;
                    j = (ptr + i) % NM;
                    if (n_own < 0 && m_cyc[j]) n_own = j;
                end
            end else begin
                n_outst = outst + (acc ? 1 : 0) - ((ackerr && outst > 0) ? 1 : 0);
                if (drn || !m_cyc[own]) begin
                    if (n_outst == 0) begin
                        n_own = -1; n_drn = 0; n_ptr = (own + 1) % NM;
                    end else begin
                        n_drn = 1;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            own = -1; drn = 0; outst = 0; ptr = 0; model_on = 1;
        end else if (model_on) begin
            own = n_own; drn = n_drn; outst = n_outst; ptr = n_ptr;
        end
    end

    // ---------------- master driver
    task automatic burst(input int k, input logic [AW-1:0] base, input int n,
                         input bit wait_acks, input bit we);
        int sent = 0, got = 0, budget = 0;
        m_cyc[k] = 1'b1;
        m_we[k]  = we;
        while ((sent < n || (wait_acks && got < n)) && budget < 400) begin
            if (sent < n) begin
                m_stb[k] = 1'b1;
                m_adr[k*AW +: AW] = base + AW'(sent);
                m_dat[k*DW +: DW] = 16'hC000 + 16'(sent);
            end else begin
                m_stb[k] = 1'b0;
            end
            @(negedge clk);
            if (m_ack[k]) got++;
            if (m_stb[k] && !m_stall[k]) sent++;
            @(posedge clk); #1;
            budget++;
        end
        chk("burst_done", budget < 400, 1);
        m_stb[k] = 1'b0;
        m_cyc[k] = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [DW-1:0] t1_exp [4] = '{16'h5A4A, 16'h5A4B, 16'h5A48, 16'h5A49};
    int a0, a1, k, guard;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_grant", grant, 2'b00);
        chk("reset_s_cyc", s_cyc, 0);
        chk("reset_stall", m_stall, 2'b11);
        chk("reset_ack", m_ack, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;

        // M0 alone: four reads, data passthrough, grant one cycle after CYC
        ack_dly = 2; rd_q.delete(); a1 = ack_cnt[1];
        fork
            burst(0, 26'h0000010, 4, 1, 0);
            begin
                @(negedge clk);
                chk("t1_grant_cycN", grant, 2'b00);
                chk("t1_stall_cycN", m_stall[0], 1);
                @(negedge clk);
                chk("t1_grant_cycN1", grant, 2'b01);
            end
        join
        chk("t1_nacks", rd_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("t1_rdata", rd_q[i], t1_exp[i]);
        chk("t1_m1_ack", ack_cnt[1] - a1, 0);
        repeat (2) @(posedge clk); #1;

        // M1 writes with a stalling slave
        stall_en = 1'b1;
        burst(1, 26'h3FFFF00, 3, 1, 1);
        stall_en = 1'b0;
        chk("t2_last_grant", gq[gq.size()-1], 2'b10);
        repeat (2) @(posedge clk); #1;

        // Simultaneous requests after reset; M0 re-raising loses to waiting M1
        pulse_reset();
        gq.delete();
        fork
            begin
                burst(0, 26'h100, 1, 1, 0);
                @(posedge clk); #1;
                burst(0, 26'h101, 1, 1, 0);
            end
            burst(1, 26'h200, 1, 1, 0);
        join
        chk("t3_ngrants", gq.size(), 3);
        chk("t3_first", gq[0], 2'b01);
        chk("t3_second", gq[1], 2'b10);
        chk("t3_third", gq[2], 2'b01);
        repeat (2) @(posedge clk); #1;

        // Six back-to-back strobes against a slow slave: full after four
        ack_dly = 10;
        fork
            burst(0, 26'h300, 6, 1, 0);
            begin
                k = 0; guard = 0;
                while (k < 4 && guard < 200) begin
                    @(negedge clk);
                    if (m_stb[0] && !m_stall[0]) k++;
                    guard++;
                end
                @(negedge clk);
                chk("t4_full_stall", m_stall[0], 1);
                chk("t4_full_nostb", s_stb, 0);
            end
        join
        @(negedge clk);
        @(negedge clk);
        chk("t4_idle_grant", grant, 2'b00);
        chk("t4_idle_cyc", s_cyc, 0);
        @(posedge clk); #1;

        // M0 drops CYC with two outstanding; late ACKs swallowed, M1 served after
        ack_dly = 8; a0 = ack_cnt[0];
        fork
            begin
                burst(0, 26'h400, 2, 0, 0);
                @(negedge clk);
                chk("t5_cyc_held", s_cyc, 1);
                @(negedge clk);
                chk("t5_drain_cyc", s_cyc, 1);
                chk("t5_drain_stb", s_stb, 0);
                chk("t5_drain_grant", grant, 2'b01);
                chk("t5_drain_stall", m_stall, 2'b11);
            end
            begin
                repeat (3) @(posedge clk); #1;
                burst(1, 26'h500, 1, 1, 0);
            end
        join
        chk("t5_no_late_ack", ack_cnt[0] - a0, 0);
        chk("t5_m1_granted", gq[gq.size()-1], 2'b10);
        repeat (2) @(posedge clk); #1;

        // Reset in BUSY with three outstanding
        ack_dly = 20;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0;
        k = 0; guard = 0;
        while (k < 3 && guard < 100) begin
            m_adr[0 +: AW] = 26'h700 + AW'(k);
            @(negedge clk);
            if (!m_stall[0]) k++;
            @(posedge clk); #1;
            guard++;
        end
        rst = 1'b1; m_stb[0] = 1'b0; m_cyc[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_cyc", s_cyc, 0);
        chk("t6_rst_grant", grant, 2'b00);
        chk("t6_rst_stall", m_stall, 2'b11);
        @(posedge clk); #1;

        // Counter restarted from zero: four strobes accepted without early stall
        ack_dly = 10;
        burst(0, 26'h800, 4, 1, 0);
        repeat (3) @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule
